div_ctrl: RTL and testbench

//  Sequences the multi-cycle iterative (radix-2, restoring) divider used by DIV/DIVU in the E stage.

---
 rtl/div_ctrl.sv | 154 +++++++++++++++
 tb/tb_div_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - E-stage radix-2 restoring divider sequencer for DIV/DIVU
//
// Purpose: runs one shift-subtract step per cycle for WIDTH cycles, freezes the
// pipeline through E_div_stall meanwhile, and presents quotient (lo) and
// remainder (hi) in the single DONE cycle where E_div_valid is high.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   E_div_start    valid DIV/DIVU in E this cycle
//   E_div_signed   1 = DIV (signed), 0 = DIVU
//   E_div_a/b      dividend / divisor
//   E_div_cancel   abort any in-flight divide (flush/exception)
//   E_div_stall    freeze request to the hazard unit
//   E_div_valid    lo/hi qualifier, one cycle in DONE
//   E_div_lo/hi    quotient / remainder, held between results
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E_div_start,
    input  logic             E_div_signed,
    input  logic [WIDTH-1:0] E_div_a,
    input  logic [WIDTH-1:0] E_div_b,
    input  logic             E_div_cancel,
    output logic             E_div_stall,
    output logic             E_div_valid,
    output logic [WIDTH-1:0] E_div_lo,
    output logic [WIDTH-1:0] E_div_hi
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;

    // Magnitudes of the operands; negating the most negative value yields the
    // same bit pattern, which is the correct unsigned magnitude 2^(W-1).
    logic [WIDTH-1:0] a_abs, b_abs;
    // One restoring step. The shifted remainder keeps the bit shifted out of
    // the top so the compare never overflows; after a successful subtract the
    // result always fits in WIDTH bits.
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_n, quo_n;

    always_comb begin
        a_abs  = (E_div_signed && E_div_a[WIDTH-1]) ? -E_div_a : E_div_a;
        b_abs  = (E_div_signed && E_div_b[WIDTH-1]) ? -E_div_b : E_div_b;
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        rem_ge = (rem_sh >= {1'b0, dvs_q});
        rem_n  = rem_ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
        quo_n  = {quo_q[WIDTH-2:0], rem_ge};
    end

    // State register and datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // Next state. Cancel wins over everything, including start.
    always_comb begin
        state_d = state_q;
        if (E_div_cancel) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (E_div_start) state_d = (E_div_b == '0) ? S_DONE : S_BUSY;
                S_BUSY:  if (cnt_q == LAST_STEP) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath next values; lo/hi only move on entry to DONE.
    always_comb begin
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        if (!E_div_cancel) begin
            if (state_q == S_IDLE && E_div_start) begin
                cnt_d   = '0;
                rem_d   = '0;
                quo_d   = a_abs;
                dvs_d   = b_abs;
                q_neg_d = E_div_signed & (E_div_a[WIDTH-1] ^ E_div_b[WIDTH-1]);
                r_neg_d = E_div_signed & E_div_a[WIDTH-1];
                if (E_div_b == '0) begin
                    lo_d = '1;
                    hi_d = E_div_a;
                end
            end else if (state_q == S_BUSY) begin
                cnt_d = cnt_q + 1'b1;
                rem_d = rem_n;
                quo_d = quo_n;
                if (cnt_q == LAST_STEP) begin
                    lo_d = q_neg_q ? -quo_n : quo_n;
                    hi_d = r_neg_q ? -rem_n : rem_n;
                end
            end
        end
    end

    // Outputs. Stall in IDLE is combinational so the start cycle itself freezes.
    always_comb begin
        E_div_stall = 1'b0;
        E_div_valid = 1'b0;
        case (state_q)
            S_IDLE:  E_div_stall = E_div_start & ~E_div_cancel & ~rst;
            S_BUSY:  E_div_stall = ~E_div_cancel & ~rst;
            S_DONE:  E_div_valid = 1'b1;
            default: E_div_stall = 1'b0;
        endcase
        E_div_lo = lo_q;
        E_div_hi = hi_q;
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        stall, valid;
    logic [31:0] lo, hi;

    int checks = 0;
    int failures = 0;
    logic hold_start = 1'b0;

    always #5 clk = ~clk;

    div_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .E_div_start(start), .E_div_signed(sgn),
        .E_div_a(a), .E_div_b(b), .E_div_cancel(cancel),
        .E_div_stall(stall), .E_div_valid(valid),
        .E_div_lo(lo), .E_div_hi(hi)
    );

    // Called #1 after the negedge of the start cycle; returns on the first
    // sampled cycle with stall low.
    task automatic wait_done(output int n);
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            #1;
        end
    endtask

    task automatic run_div(input string name, input logic s, input logic [31:0] ia, input logic [31:0] ib,
                           input int exp_n, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int n;
        @(negedge clk);
        cancel = 1'b0; start = 1'b1; sgn = s; a = ia; b = ib;
        #1;
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL %s start_valid got=%b want=0", name, valid); end
        wait_done(n);
        checks++;
        if (n != exp_n) begin failures++; $display("FAIL %s stall_cycles got=%0d want=%0d", name, n, exp_n); end
        checks++;
        if (valid !== 1'b1 || lo !== exp_lo || hi !== exp_hi) begin
            failures++;
            $display("FAIL %s result got valid=%b lo=%h hi=%h want valid=1 lo=%h hi=%h", name, valid, lo, hi, exp_lo, exp_hi);
        end
        @(negedge clk); #1;
        checks++;
        if (valid !== 1'b0 || stall !== 1'b0) begin
            failures++; $display("FAIL %s after_done got valid=%b stall=%b want 0/0", name, valid, stall);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (stall !== 1'b0 || valid !== 1'b0 || lo !== 32'h0 || hi !== 32'h0) begin
            failures++; $display("FAIL reset got stall=%b valid=%b lo=%h hi=%h want 0", stall, valid, lo, hi);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (stall !== 1'b0 || valid !== 1'b0) begin
            failures++; $display("FAIL reset_release got stall=%b valid=%b want 0/0", stall, valid);
        end
    endtask

    task automatic test_divu();
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    endtask

    task automatic test_signed();
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
    endtask

    task automatic test_overflow();
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
        run_div("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    endtask

    task automatic test_div_zero();
        run_div("divu_zero", 1'b0, 32'h1234, 32'd0, 1, 32'hFFFF_FFFF, 32'h1234);
        run_div("div_zero", 1'b1, 32'hFFFF_FF00, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FF00);
    endtask

    // Previous result is div_zero: lo=FFFFFFFF hi=FFFFFF00, which must hold.
    task automatic test_cancel();
        int k;
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
        #1;
        for (k = 0; k <= 10; k++) begin
            @(negedge clk); start = 1'b0;
            if (k == 10) cancel = 1'b1;
            #1;
            if (k < 10) begin
                checks++;
                if (stall !== 1'b1 || valid !== 1'b0) begin
                    failures++; $display("FAIL cancel_busy%0d got stall=%b valid=%b want 1/0", k, stall, valid);
                end
            end
        end
        checks++;
        if (stall !== 1'b0 || valid !== 1'b0) begin
            failures++; $display("FAIL cancel_cycle got stall=%b valid=%b want 0/0", stall, valid);
        end
        checks++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FF00) begin
            failures++; $display("FAIL cancel_hold got lo=%h hi=%h want lo=ffffffff hi=ffffff00", lo, hi);
        end
        run_div("after_cancel", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);
    endtask

    // Start held high through DONE: DONE must ignore it, and the following
    // IDLE cycle must accept the next divide immediately.
    task automatic test_back_to_back();
        int n;
        hold_start = 1'b1;
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 32'd20; b = 32'd6;
        #1;
        wait_done(n);
        checks++;
        if (n != 33 || valid !== 1'b1 || lo !== 32'd3 || hi !== 32'd2) begin
            failures++; $display("FAIL b2b_first got n=%0d valid=%b lo=%h hi=%h want 33/1/3/2", n, valid, lo, hi);
        end
        @(negedge clk);
        a = 32'd50; b = 32'd5;
        #1;
        checks++;
        if (stall !== 1'b1 || valid !== 1'b0) begin
            failures++; $display("FAIL b2b_accept got stall=%b valid=%b want 1/0", stall, valid);
        end
        hold_start = 1'b0;
        wait_done(n);
        checks++;
        if (n != 33 || valid !== 1'b1 || lo !== 32'd10 || hi !== 32'd0) begin
            failures++; $display("FAIL b2b_second got n=%0d valid=%b lo=%h hi=%h want 33/1/a/0", n, valid, lo, hi);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; a = 32'd100; b = 32'd7;
        repeat (5) begin @(negedge clk); start = 1'b0; end
        #3;
        checks++;
        if (stall !== 1'b1 || lo !== 32'd10) begin
            failures++; $display("FAIL pre_reset got stall=%b lo=%h want 1/a", stall, lo);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0 || valid !== 1'b0 || lo !== 32'h0 || hi !== 32'h0) begin
            failures++; $display("FAIL async_reset got stall=%b valid=%b lo=%h hi=%h want 0", stall, valid, lo, hi);
        end
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b0;
        run_div("post_reset", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_overflow();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
